// File: rtl/gecko_memory_arbiter_pkg.sv
// Shared types and defaults for the gecko memory arbiter.
package gecko;

  // Default depth of the outstanding-read tag FIFO.
  localparam int GECKO_ARBITER_MAX_OUTSTANDING = 4;

  // Names which requester a memory read belongs to.
  typedef enum logic {
    TAG_INST = 1'b0,
    TAG_DATA = 1'b1
  } gecko_arbiter_tag_t;

  // Grant FSM: IDLE picks a winner each cycle, LOCKED pins it until handshake.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } gecko_arbiter_state_t;

  // The requester that did not win last time.
  function automatic gecko_arbiter_tag_t other_tag(input gecko_arbiter_tag_t tag);
    return (tag == TAG_INST) ? TAG_DATA : TAG_INST;
  endfunction

endpackage

// File: rtl/gecko_memory_arbiter_if.sv
// Valid/ready memory channel. The "in" side receives a transfer, "out" sends it.
interface std_mem_intf;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  write_enable;

  modport in  (input valid, addr, data, write_enable, output ready);
  modport out (output valid, addr, data, write_enable, input ready);
endinterface

// File: rtl/gecko_memory_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit requester tags, one entry per outstanding read.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module gecko_arbiter_tag_fifo
  import gecko::*;
#(
  parameter int DEPTH = GECKO_ARBITER_MAX_OUTSTANDING
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  gecko_arbiter_tag_t push_tag,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output gecko_arbiter_tag_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  gecko_arbiter_tag_t tags [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = tags[rd_ptr];

  // Tag storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) tags[wr_ptr] <= push_tag;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gecko_memory_arbiter.sv
// Shares one in-order memory port between instruction fetch and load/store.
// Requests are forwarded combinationally; read results are steered back by a
// tag FIFO recording which requester issued each outstanding read.
module gecko_memory_arbiter
  import gecko::*;
#(
  parameter int MAX_OUTSTANDING = GECKO_ARBITER_MAX_OUTSTANDING,
  parameter int DATA_FIRST      = 1
) (
  input  logic       clk,
  input  logic       rst,
  std_mem_intf.in    inst_request,
  std_mem_intf.out   inst_result,
  std_mem_intf.in    data_request,
  std_mem_intf.out   data_result,
  std_mem_intf.out   mem_request,
  std_mem_intf.in    mem_result,
  output logic       fault_flag
);

  // Seeding last_grant with the opposite side makes the first contention
  // go the DATA_FIRST way.
  localparam gecko_arbiter_tag_t RESET_LAST = (DATA_FIRST != 0) ? TAG_INST : TAG_DATA;

  gecko_arbiter_state_t state;
  gecko_arbiter_tag_t   locked_grant;
  gecko_arbiter_tag_t   last_grant;
  gecko_arbiter_tag_t   grant;
  gecko_arbiter_tag_t   head_tag;
  logic                 sel_valid;
  logic                 can_push;
  logic                 req_handshake;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 unused_bits;

  // Winner selection: a locked grant is held, otherwise round-robin on contention.
  always_comb begin
    grant = TAG_INST;
    if (state == ARB_LOCKED) begin
      grant = locked_grant;
    end else if (inst_request.valid && data_request.valid) begin
      grant = other_tag(last_grant);
    end else if (data_request.valid) begin
      grant = TAG_DATA;
    end
  end

  // Every request (read or write) is held off while the FIFO is full, except
  // in a cycle where a result pop frees a slot.
  assign sel_valid = (grant == TAG_DATA) ? data_request.valid : inst_request.valid;
  assign pop       = !rst && mem_result.valid && mem_result.ready && !fifo_empty;
  assign can_push  = !fifo_full || pop;

  assign mem_request.valid        = !rst && sel_valid && can_push;
  assign mem_request.addr         = (grant == TAG_DATA) ? data_request.addr : inst_request.addr;
  assign mem_request.data         = (grant == TAG_DATA) ? data_request.data : inst_request.data;
  assign mem_request.write_enable = (grant == TAG_DATA) ? data_request.write_enable
                                                        : inst_request.write_enable;

  assign inst_request.ready = !rst && (grant == TAG_INST) && can_push && mem_request.ready;
  assign data_request.ready = !rst && (grant == TAG_DATA) && can_push && mem_request.ready;

  assign req_handshake = mem_request.valid && mem_request.ready;
  assign push          = req_handshake && (mem_request.write_enable == '0);

  // Results go to the requester at the FIFO head; with nothing outstanding the
  // result is swallowed (ready = 1) and flagged.
  assign inst_result.valid        = !rst && !fifo_empty && (head_tag == TAG_INST) && mem_result.valid;
  assign data_result.valid        = !rst && !fifo_empty && (head_tag == TAG_DATA) && mem_result.valid;
  assign inst_result.data         = mem_result.data;
  assign data_result.data         = mem_result.data;
  assign inst_result.addr         = '0;
  assign data_result.addr         = '0;
  assign inst_result.write_enable = '0;
  assign data_result.write_enable = '0;
  assign mem_result.ready = fifo_empty ? 1'b1
                          : ((head_tag == TAG_INST) ? inst_result.ready : data_result.ready);

  assign unused_bits = ^{mem_result.addr, mem_result.write_enable};

  gecko_arbiter_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (grant),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_tag)
  );

  // Grant FSM: lock a presented-but-unaccepted grant so its payload stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      locked_grant <= TAG_INST;
      last_grant   <= RESET_LAST;
    end else begin
      if (req_handshake) last_grant <= grant;
      case (state)
        ARB_IDLE: begin
          if (sel_valid && !req_handshake) begin
            state        <= ARB_LOCKED;
            locked_grant <= grant;
          end
        end
        ARB_LOCKED: begin
          if (req_handshake || !sel_valid) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Sticky flag for a result that arrived with no read outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_flag <= 1'b0;
    end else if (mem_result.valid && fifo_empty) begin
      fault_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gecko_memory_arbiter.sv
// Directed bench for gecko_memory_arbiter (MAX_OUTSTANDING = 2, DATA_FIRST = 1).
module tb_gecko_memory_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault_flag;
  int   n_checks = 0;
  int   n_fail   = 0;

  std_mem_intf inst_req ();
  std_mem_intf inst_res ();
  std_mem_intf data_req ();
  std_mem_intf data_res ();
  std_mem_intf mem_req ();
  std_mem_intf mem_res ();

  gecko_memory_arbiter #(
    .MAX_OUTSTANDING (2),
    .DATA_FIRST      (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_request (inst_req),
    .inst_result  (inst_res),
    .data_request (data_req),
    .data_result  (data_res),
    .mem_request  (mem_req),
    .mem_result   (mem_res),
    .fault_flag   (fault_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic        dv;
    logic        mrdy;
    logic        mvalid;
    logic [31:0] maddr;
    logic        irdy;
    logic        drdy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic iv, input logic [31:0] ia, input logic [3:0] iwe,
                         input logic dv, input logic [31:0] da, input logic [3:0] dwe,
                         input logic mrdy);
    inst_req.valid        = iv;
    inst_req.addr         = ia;
    inst_req.data         = 32'h0;
    inst_req.write_enable = iwe;
    data_req.valid        = dv;
    data_req.addr         = da;
    data_req.data         = da ^ 32'h5a5a_0000;
    data_req.write_enable = dwe;
    mem_req.ready         = mrdy;
  endtask

  task automatic set_res(input logic v, input logic [31:0] d);
    mem_res.valid = v;
    mem_res.data  = d;
  endtask

  initial begin
    set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    set_res(1'b0, 32'h0);
    mem_res.addr         = 32'h0;
    mem_res.write_enable = 4'h0;
    inst_res.ready       = 1'b1;
    data_res.ready       = 1'b1;

    // Reset state, with live inputs that must be ignored.
    repeat (2) tick();
    set_req(1'b1, 32'h10, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    set_res(1'b1, 32'hdead);
    tick();
    chk("rst mem_req.valid", mem_req.valid, 0);
    chk("rst inst_req.ready", inst_req.ready, 0);
    chk("rst inst_res.valid", inst_res.valid, 0);
    chk("rst mem_res.ready", mem_res.ready, 1);
    chk("rst fault_flag", fault_flag, 0);
    set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    set_res(1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Arbitration table (writes only, so the FIFO stays empty). inst = 0x1000, data = 0x2000.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      set_req(vecs[i].iv, 32'h1000, 4'hf, vecs[i].dv, 32'h2000, 4'hf, vecs[i].mrdy);
      @(negedge clk);
      chk($sformatf("vec%0d mem_req.valid", i), mem_req.valid, vecs[i].mvalid);
      chk($sformatf("vec%0d mem_req.addr", i), mem_req.addr, vecs[i].maddr);
      chk($sformatf("vec%0d inst_req.ready", i), inst_req.ready, vecs[i].irdy);
      chk($sformatf("vec%0d data_req.ready", i), data_req.ready, vecs[i].drdy);
      tick();
    end
    set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);

    // Instruction-only reads 0x0/0x4/0x8 answered with A/B/C.
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 32'(4 * k), 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      chk($sformatf("iread%0d mem_req.addr", k), mem_req.addr, 32'(4 * k));
      chk($sformatf("iread%0d inst_req.ready", k), inst_req.ready, 1);
      tick();
      set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
      set_res(1'b1, 32'(10 + k));
      @(negedge clk);
      chk($sformatf("iread%0d inst_res.valid", k), inst_res.valid, 1);
      chk($sformatf("iread%0d inst_res.data", k), inst_res.data, 32'(10 + k));
      chk($sformatf("iread%0d data_res.valid", k), data_res.valid, 0);
      tick();
      set_res(1'b0, 32'h0);
    end

    // Data read held for 3 cycles by mem ready = 0 while inst waits.
    set_req(1'b1, 32'h80, 4'h0, 1'b1, 32'h40, 4'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d mem_req.addr", c), mem_req.addr, 32'h40);
      chk($sformatf("hold%0d mem_req.valid", c), mem_req.valid, 1);
      chk($sformatf("hold%0d inst_req.ready", c), inst_req.ready, 0);
      tick();
    end
    mem_req.ready = 1'b1;
    @(negedge clk);
    chk("hold release mem_req.addr", mem_req.addr, 32'h40);
    chk("hold release data_req.ready", data_req.ready, 1);
    tick();
    data_req.valid = 1'b0;
    @(negedge clk);
    chk("after hold mem_req.addr", mem_req.addr, 32'h80);
    chk("after hold inst_req.ready", inst_req.ready, 1);
    tick();
    set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);

    // Two reads outstanding (full): third read stalls until the first result pops.
    set_req(1'b1, 32'hc0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("full%0d mem_req.valid", c), mem_req.valid, 0);
      chk($sformatf("full%0d inst_req.ready", c), inst_req.ready, 0);
      tick();
    end
    set_res(1'b1, 32'h55);
    @(negedge clk);
    chk("pop data_res.valid", data_res.valid, 1);
    chk("pop data_res.data", data_res.data, 32'h55);
    chk("pop inst_res.valid", inst_res.valid, 0);
    chk("pop mem_req.valid", mem_req.valid, 1);
    chk("pop inst_req.ready", inst_req.ready, 1);
    tick();
    set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    set_res(1'b1, 32'h66);
    @(negedge clk);
    chk("res66 inst_res.valid", inst_res.valid, 1);
    chk("res66 inst_res.data", inst_res.data, 32'h66);
    tick();
    set_res(1'b1, 32'h77);
    @(negedge clk);
    chk("res77 inst_res.valid", inst_res.valid, 1);
    chk("res77 inst_res.data", inst_res.data, 32'h77);
    tick();
    set_res(1'b0, 32'h0);

    // Store then load with one result, then an unsolicited result.
    set_req(1'b0, 32'h0, 4'h0, 1'b1, 32'h200, 4'hf, 1'b1);
    @(negedge clk);
    chk("store mem_req.valid", mem_req.valid, 1);
    chk("store mem_req.addr", mem_req.addr, 32'h200);
    tick();
    set_req(1'b0, 32'h0, 4'h0, 1'b1, 32'h204, 4'h0, 1'b1);
    @(negedge clk);
    chk("load mem_req.addr", mem_req.addr, 32'h204);
    chk("load data_req.ready", data_req.ready, 1);
    tick();
    set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    set_res(1'b1, 32'h99);
    @(negedge clk);
    chk("load data_res.valid", data_res.valid, 1);
    chk("load data_res.data", data_res.data, 32'h99);
    chk("load inst_res.valid", inst_res.valid, 0);
    tick();
    chk("load fault_flag", fault_flag, 0);
    set_res(1'b1, 32'hee);
    @(negedge clk);
    chk("extra inst_res.valid", inst_res.valid, 0);
    chk("extra data_res.valid", data_res.valid, 0);
    chk("extra mem_res.ready", mem_res.ready, 1);
    chk("extra fault_flag before edge", fault_flag, 0);
    tick();
    set_res(1'b0, 32'h0);
    @(negedge clk);
    chk("extra fault_flag set", fault_flag, 1);
    tick();
    chk("fault_flag sticky", fault_flag, 1);

    // Reset with two reads outstanding.
    set_req(1'b1, 32'h300, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    tick();
    inst_req.addr = 32'h304;
    @(negedge clk);
    tick();
    inst_req.addr = 32'h308;
    set_res(1'b1, 32'h1);
    #1;
    chk("pre-reset inst_res.valid", inst_res.valid, 1);
    rst = 1'b1;
    #1;
    chk("mid-reset mem_req.valid", mem_req.valid, 0);
    chk("mid-reset inst_res.valid", inst_res.valid, 0);
    chk("mid-reset data_res.valid", data_res.valid, 0);
    chk("mid-reset fault_flag", fault_flag, 0);
    chk("mid-reset mem_res.ready", mem_res.ready, 1);
    set_res(1'b0, 32'h0);
    set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    set_req(1'b1, 32'h400, 4'h0, 1'b1, 32'h404, 4'h0, 1'b1);
    @(negedge clk);
    chk("post-reset first grant addr", mem_req.addr, 32'h404);
    chk("post-reset data_req.ready", data_req.ready, 1);
    tick();
    data_req.valid = 1'b0;
    @(negedge clk);
    chk("post-reset second grant addr", mem_req.addr, 32'h400);
    tick();
    set_req(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    set_res(1'b1, 32'h1111);
    @(negedge clk);
    chk("post-reset data_res.valid", data_res.valid, 1);
    chk("post-reset data_res.data", data_res.data, 32'h1111);
    tick();
    set_res(1'b1, 32'h2222);
    @(negedge clk);
    chk("post-reset inst_res.valid", inst_res.valid, 1);
    chk("post-reset inst_res.data", inst_res.data, 32'h2222);
    tick();
    set_res(1'b0, 32'h0);
    chk("post-reset fault_flag", fault_flag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gecko_memory_arbiter.md
GECKO_MEMORY_ARBITER -- requirements
Module: gecko_memory_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, giving the maximum number of reads accepted but not yet answered (range 1..16).
REQ-002 SHALL have parameter DATA_FIRST, default 1; on the first contention after reset, 1 grants the data requester and 0 grants the instruction requester.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port inst_request, std_mem_intf.in, addr 32 / data 32: the instruction-fetch request.
REQ-006 SHALL have port inst_result, std_mem_intf.out, data 32: the instruction read result.
REQ-007 SHALL have port data_request, std_mem_intf.in, addr 32 / data 32: the load/store request.
REQ-008 SHALL have port data_result, std_mem_intf.out, data 32: the load result.
REQ-009 SHALL have port mem_request, std_mem_intf.out, addr 32 / data 32: the shared memory request.
REQ-010 SHALL have port mem_result, std_mem_intf.in, data 32: the shared memory result, returned in request order.
REQ-011 SHALL have port fault_flag, output, 1 bit: sticky, set when a result arrives with no read outstanding.

Function
REQ-012 SHALL forward the granted requester's payload to mem_request combinationally, with zero added latency.
REQ-013 SHALL drive mem_request.valid only when a requester is valid and the tag FIFO can accept; mem_request.ready SHALL reach only the granted requester.
REQ-014 SHALL use a 2-state grant FSM, IDLE and LOCKED.
- IDLE: a single valid requester wins.
- IDLE with both valid: the requester not granted last wins (round-robin).
REQ-015 SHALL move from IDLE to LOCKED when a grant is presented but no handshake occurs, and SHALL hold that grant in LOCKED until the handshake, so the payload stays stable.
REQ-016 SHALL return from LOCKED to IDLE on handshake and SHALL update last_grant on every accepted request.
REQ-017 SHALL push a 1-bit tag (0 = inst, 1 = data) into an in-order FIFO of depth MAX_OUTSTANDING on each accepted read (write_enable all zero); accepted writes SHALL push nothing.
REQ-018 SHALL route mem_result to the requester named by the FIFO head.
- valid goes only to that requester; the other sees valid = 0.
- mem_result.ready SHALL equal that requester's ready.
REQ-019 SHALL pop the FIFO head on each mem_result handshake.
REQ-020 SHALL allow a push into a full FIFO in a cycle with a simultaneous pop; outstanding count = pushes - pops, saturating at neither bound.
REQ-021 SHALL hold mem_result.ready = 1 when the FIFO is empty, discard that result, and set fault_flag.
REQ-022 SHALL clear fault_flag only by reset.
REQ-023 SHALL stall new reads and any further data-path grants when the FIFO is full, until a pop.

Reset
REQ-024 SHALL, while rst is high (asynchronous), hold the following values:
- FSM = IDLE, FIFO empty, outstanding = 0.
- last_grant = inst if DATA_FIRST = 1, else data.
- fault_flag = 0, all valid outputs 0.
REQ-025 SHALL discard in-flight tags on reset mid-operation; the first cycle after rst falls SHALL behave as a fresh start.

Structure
REQ-026 SHALL place gecko_arbiter_tag_t (the 1-bit enum INST/DATA) and GECKO_ARBITER_MAX_OUTSTANDING in package gecko.
REQ-027 SHALL implement the tag FIFO as sub-module gecko_arbiter_tag_fifo (parameter DEPTH; push/pop/full/empty/head).

Verification
REQ-028 SHALL cover: inst-only reads at 0x0, 0x4, 0x8 with result data 0xA, 0xB, 0xC -> inst_result returns A, B, C in order; data_result.valid is never 1.
REQ-029 SHALL cover: both requesters valid for 6 cycles with mem ready = 1 and DATA_FIRST = 1 -> grant order D, I, D, I, D, I.
REQ-030 SHALL cover: data read granted with mem ready = 0 for 3 cycles while inst is valid -> grant held on data, payload stable, inst granted on the cycle after the handshake.
REQ-031 SHALL cover: MAX_OUTSTANDING = 2 and three reads without results -> the third read stalls; it is accepted the same cycle the first result pops.
REQ-032 SHALL cover: a store then a load, with one result -> the result goes to data_result, fault_flag stays 0; an extra unsolicited result -> fault_flag = 1.
REQ-033 SHALL cover: rst asserted with 2 reads outstanding -> all outputs at reset values immediately; after release, a new read completes normally.
